// File: rtl/my_chip.sv
// Read-only message store: 64 strings "Design NN", one per project index.
// The pin index is double-synchronized, then the looked-up byte is registered.
module my_chip (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] io_in,
  output logic [7:0]  io_out
);

  logic [11:0] sync_1;
  logic [11:0] sync_2;
  logic [5:0]  proj_idx;
  logic [5:0]  chr_idx;
  logic [3:0]  tens_digit;
  logic [3:0]  ones_digit;
  logic [7:0]  rom_byte;

  assign proj_idx = sync_2[11:6];
  assign chr_idx  = sync_2[5:0];

  // Projects stop at 63, so both digits fit in four bits.
  assign tens_digit = 4'(proj_idx / 6'd10);
  assign ones_digit = 4'(proj_idx % 6'd10);

  always_comb begin
    rom_byte = 8'h00;
    case (chr_idx)
      6'd0:    rom_byte = 8'h44;
      6'd1:    rom_byte = 8'h65;
      6'd2:    rom_byte = 8'h73;
      6'd3:    rom_byte = 8'h69;
      6'd4:    rom_byte = 8'h67;
      6'd5:    rom_byte = 8'h6E;
      6'd6:    rom_byte = 8'h20;
      6'd7:    rom_byte = 8'h30 + {4'h0, tens_digit};
      6'd8:    rom_byte = 8'h30 + {4'h0, ones_digit};
      default: rom_byte = 8'h00;
    endcase
  end

  // Reset clears every stage so no stale index survives it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_1 <= 12'h000;
      sync_2 <= 12'h000;
      io_out <= 8'h00;
    end else begin
      sync_1 <= io_in;
      sync_2 <= sync_1;
      io_out <= rom_byte;
    end
  end

endmodule

// File: tb/tb_my_chip.sv
// Scoreboard bench for my_chip: stimulus queues expected bytes with a due cycle,
// a negedge monitor pops and compares them.
module tb_my_chip;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] io_in = 12'h000;
  logic [7:0]  io_out;

  int cycle_count = 0;
  int total_checks = 0;
  int bad_checks = 0;

  typedef struct {
    int         due;
    logic [7:0] exp;
    logic [7:0] alt;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  my_chip dut (
    .clock (clock),
    .reset (reset),
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle_count <= cycle_count + 1;

  function automatic logic [7:0] model_byte(input int p, input int c);
    logic [7:0] b;
    case (c)
      0: b = 8'h44;
      1: b = 8'h65;
      2: b = 8'h73;
      3: b = 8'h69;
      4: b = 8'h67;
      5: b = 8'h6E;
      6: b = 8'h20;
      7: b = 8'(8'h30 + (p / 10));
      8: b = 8'(8'h30 + (p % 10));
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  task automatic check_output(input string name, input logic [7:0] act,
                              input logic [7:0] exp, input logic [7:0] alt);
    total_checks++;
    if (act !== exp && act !== alt) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h (or 0x%02h) at cycle %0d",
               name, act, exp, alt, cycle_count);
    end
  endtask

  task automatic push_expect(input int due, input logic [7:0] exp,
                             input logic [7:0] alt, input string name);
    exp_t e;
    e.due  = due;
    e.exp  = exp;
    e.alt  = alt;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Drive one index just after an edge and hold it for 'hold' cycles.
  task automatic apply_stimulus(input int p, input int c, input int hold,
                                input logic [7:0] exp, input string name);
    @(posedge clock);
    #1;
    io_in = {6'(p), 6'(c)};
    push_expect(cycle_count + ((hold < 3) ? 3 : hold), exp, exp, name);
    repeat (hold - 1) @(posedge clock);
  endtask

  task automatic drain_queue();
    repeat (10) @(posedge clock);
  endtask

  always @(negedge clock) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].due <= cycle_count) begin
      e = exp_q.pop_front();
      if (e.due < cycle_count) begin
        total_checks++;
        bad_checks++;
        $display("[TB] FAIL %s: sample missed, due cycle %0d now %0d",
                 e.name, e.due, cycle_count);
      end else begin
        check_output(e.name, io_out, e.exp, e.alt);
      end
    end
  end

  logic [7:0] design00 [10];
  int vec_p [6];
  int vec_c [6];
  logic [7:0] vec_exp [6];

  initial begin
    int k;
    design00 = '{8'h44, 8'h65, 8'h73, 8'h69, 8'h67, 8'h6E, 8'h20, 8'h30, 8'h30, 8'h00};
    vec_p    = '{5, 5, 63, 63, 10, 10};
    vec_c    = '{7, 8, 7, 8, 7, 8};
    vec_exp  = '{8'h30, 8'h35, 8'h36, 8'h33, 8'h31, 8'h30};

    // Reset with no clock edge yet, then held across edges.
    io_in = 12'hABC;
    #1 reset = 1'b1;
    #1 check_output("reset_async", io_out, 8'h00, 8'h00);
    repeat (2) @(posedge clock);
    #1 check_output("reset_hold", io_out, 8'h00, 8'h00);

    // Release with io_in held: index 42/60 is a terminator.
    @(posedge clock);
    #1 reset = 1'b0;
    k = cycle_count;
    push_expect(k + 1, 8'h44, 8'h00, "post_reset_e1");
    push_expect(k + 2, 8'h44, 8'h00, "post_reset_e2");
    push_expect(k + 3, 8'h00, 8'h00, "post_reset_e3");
    drain_queue();

    for (int c = 0; c < 10; c++)
      apply_stimulus(0, c, 8, design00[c], "proj0_string");

    for (int i = 0; i < 6; i++)
      apply_stimulus(vec_p[i], vec_c[i], 8, vec_exp[i], "digit_vec");

    // Latency step from {0,0} to {1,8}.
    apply_stimulus(0, 0, 8, 8'h44, "latency_pre");
    @(posedge clock);
    #1;
    io_in = {6'd1, 6'd8};
    k = cycle_count;
    push_expect(k + 1, 8'h44, 8'h44, "latency_e1");
    push_expect(k + 2, 8'h44, 8'h44, "latency_e2");
    push_expect(k + 3, 8'h31, 8'h31, "latency_e3");
    repeat (7) @(posedge clock);

    // Index changes every cycle across all tail positions.
    for (int p = 0; p < 64; p++) begin
      for (int c = 9; c < 64; c++)
        apply_stimulus(p, c, 1, 8'h00, "tail_zero");
      apply_stimulus(p, 0, 1, 8'h44, "chr0_d");
    end
    drain_queue();

    // Host-style sweep with a reset pulse part way through.
    for (int p = 0; p < 64; p++) begin
      for (int c = 0; c < 10; c++) begin
        if (p == 32 && c == 4) begin
          drain_queue();
          @(posedge clock);
          #1 io_in = {6'd32, 6'd4};
          @(posedge clock);
          #1 reset = 1'b1;
          #1 check_output("reset_mid", io_out, 8'h00, 8'h00);
          repeat (2) @(posedge clock);
          #1 reset = 1'b0;
          k = cycle_count;
          push_expect(k + 1, 8'h44, 8'h00, "mid_reset_e1");
          push_expect(k + 2, 8'h44, 8'h00, "mid_reset_e2");
          push_expect(k + 3, 8'h67, 8'h67, "mid_reset_e3");
          repeat (2) @(posedge clock);
        end
        apply_stimulus(p, c, 8, model_byte(p, c), "sweep");
      end
    end

    repeat (12) @(posedge clock);
    if (exp_q.size() != 0) begin
      total_checks++;
      bad_checks++;
      $display("[TB] FAIL scoreboard_leftover: %0d entries remain, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
